pwm_multi: RTL and testbench

- N-channel PWM generator with a shared WIDTH-bit period counter, per-channel double-buffered duty registers and a selectable edge- or center-aligned mode.
- Successor to the single-channel fixed 10-bit PWM used for motor/LED drive.
- Host writes duties at any time; updates take effect only at the period boundary, so every period is glitch-free.

---
 rtl/pwm_multi_if.sv | 14 +
 rtl/pwm_multi.sv | 113 +++++++++++
 tb/tb_pwm_multi.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_if.sv
// Duty-write bus for pwm_multi: one strobe, a channel index and the duty value.
interface pwm_multi_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 10
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [WIDTH-1:0] wr_duty;

  modport master (output wr_en, wr_ch, wr_duty);
  modport slave  (input  wr_en, wr_ch, wr_duty);
endinterface

// File: rtl/pwm_multi.sv
// N-channel PWM with shared counter, double-buffered duties, edge/center mode.
// Optional output polarity control when PWM_POLARITY_EN is defined.
module pwm_multi_lane #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr_hit,
  input  logic             load,
  input  logic [WIDTH-1:0] wr_duty,
  input  logic [WIDTH-1:0] cnt,
  output logic             pwm_raw
);
  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] shadow, active;

  // active samples the pre-write shadow, so a write on the load edge waits a period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      active  <= '0;
      pwm_raw <= 1'b0;
    end else begin
      if (wr_hit) shadow <= wr_duty;
      if (load)   active <= shadow;
      pwm_raw <= en && ((active == MAX) || (cnt < active));
    end
  end
endmodule

module pwm_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  pwm_multi_if.slave          wr,
`ifdef PWM_POLARITY_EN
  input  logic [CHANNELS-1:0] pol,
`endif
  output logic [CHANNELS-1:0] pwm,
  output logic                period_pulse
);
  localparam int               CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [WIDTH-1:0] MAX  = '1;

  logic [WIDTH-1:0]    cnt, cnt_nxt;
  logic                dir, dir_nxt;   // 0 = up, 1 = down
  logic                mode_act;
  logic                boundary;
  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] pwm_raw;

  always_comb begin
    cnt_nxt = cnt + 1'b1;
    dir_nxt = dir;
    if (!en) begin
      cnt_nxt = '0;
      dir_nxt = 1'b0;
    end else if (mode_act) begin
      if (dir)              cnt_nxt = cnt - 1'b1;
      else if (cnt == MAX) begin
        cnt_nxt = cnt - 1'b1;
        dir_nxt = 1'b1;
      end
    end
    if (cnt_nxt == '0) dir_nxt = 1'b0;
  end

  // Disabled holds cnt_nxt at 0, so duties and mode reload every idle cycle too
  assign boundary = (cnt_nxt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      dir          <= 1'b0;
      mode_act     <= 1'b0;
      period_pulse <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      dir          <= dir_nxt;
      if (boundary) mode_act <= mode;
      period_pulse <= en && (cnt == '0);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    assign wr_hit[i] = wr.wr_en && (wr.wr_ch == CH_W'(i));
    pwm_multi_lane #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .wr_hit  (wr_hit[i]),
      .load    (boundary),
      .wr_duty (wr.wr_duty),
      .cnt     (cnt),
      .pwm_raw (pwm_raw[i])
    );
  end

`ifdef PWM_POLARITY_EN
  // Unreset so the idle level follows pol even while rst_n is held low
  logic [CHANNELS-1:0] pol_q;
  always_ff @(posedge clk) pol_q <= pol;
  assign pwm = pwm_raw ^ pol_q;
`else
  assign pwm = pwm_raw;
`endif
endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi (CHANNELS=3, WIDTH=4, MAX=15).
module tb_pwm_multi;
  localparam int CHANNELS = 3;
  localparam int WIDTH    = 4;

  logic       clk = 1'b0;
  logic       rst_n, en, mode;
  logic [2:0] pwm;
  logic       period_pulse;
`ifdef PWM_POLARITY_EN
  logic [2:0] pol;
`endif
  int vecs = 0;
  int errs = 0;
  logic [63:0] cap0, cap1, cap2, cap_pp;

  pwm_multi_if #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) wr_if ();

  pwm_multi #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .mode         (mode),
    .wr           (wr_if.slave),
`ifdef PWM_POLARITY_EN
    .pol          (pol),
`endif
    .pwm          (pwm),
    .period_pulse (period_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input int ch, input int duty);
    wr_if.wr_en   = 1'b1;
    wr_if.wr_ch   = 2'(ch);
    wr_if.wr_duty = 4'(duty);
    tick();
    wr_if.wr_en   = 1'b0;
  endtask

  task automatic sample(input int j);
    cap0[j]   = pwm[0];
    cap1[j]   = pwm[1];
    cap2[j]   = pwm[2];
    cap_pp[j] = period_pulse;
  endtask

  task automatic capture(input int n);
    cap0 = '0; cap1 = '0; cap2 = '0; cap_pp = '0;
    for (int j = 0; j < n; j++) begin
      sample(j);
      if (j < n - 1) tick();
    end
  endtask

  // Leaves the bench on the negedge where pwm shows cnt=0
  task automatic sync_pulse();
    int n = 0;
    do begin
      tick();
      n++;
    end while (period_pulse !== 1'b1 && n < 100);
    if (period_pulse !== 1'b1) begin
      vecs++; errs++;
      $display("FAIL sync_pulse: no period_pulse within 100 cycles");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = 1'b0;
    wr_if.wr_en = 1'b0; wr_if.wr_ch = '0; wr_if.wr_duty = '0;
`ifdef PWM_POLARITY_EN
    pol = 3'b000;
`endif
    repeat (3) tick();
    vecs++; if (pwm !== 3'b000) begin errs++; $display("FAIL reset_pwm: got %b want 000", pwm); end
    vecs++; if (period_pulse !== 1'b0) begin errs++; $display("FAIL reset_pulse: got %b want 0", period_pulse); end
    en = 1'b1; rst_n = 1'b1;
    tick();
    vecs++; if (period_pulse !== 1'b1) begin errs++; $display("FAIL first_pulse: got %b want 1", period_pulse); end
    tick();
    vecs++; if (period_pulse !== 1'b0) begin errs++; $display("FAIL pulse_one_cycle: got %b want 0", period_pulse); end
  endtask

  task automatic test_edge();
    en = 1'b0;
    wr(0, 5); wr(1, 0); wr(2, 15);
    repeat (2) tick();
    en = 1'b1;
    sync_pulse();
    capture(17);
    vecs++; if (cap0[15:0] !== 16'h001F) begin errs++; $display("FAIL edge_ch0: got %h want 001f", cap0[15:0]); end
    vecs++; if (cap1[15:0] !== 16'h0000) begin errs++; $display("FAIL edge_ch1: got %h want 0000", cap1[15:0]); end
    vecs++; if (cap2[15:0] !== 16'hFFFF) begin errs++; $display("FAIL edge_ch2: got %h want ffff", cap2[15:0]); end
    vecs++; if (cap_pp[16:0] !== 17'h10001) begin errs++; $display("FAIL edge_pulse: got %h want 10001", cap_pp[16:0]); end
  endtask

  task automatic test_shadow();
    sync_pulse();
    cap0 = '0; cap1 = '0; cap2 = '0; cap_pp = '0;
    for (int j = 0; j < 48; j++) begin
      sample(j);
      wr_if.wr_ch = 2'd0;
      if (j == 2)       begin wr_if.wr_en = 1'b1; wr_if.wr_duty = 4'd8; end
      else if (j == 14) begin wr_if.wr_en = 1'b1; wr_if.wr_duty = 4'd2; end
      else                    wr_if.wr_en = 1'b0;
      if (j < 47) tick();
    end
    wr_if.wr_en = 1'b0;
    vecs++; if (cap0[15:0]  !== 16'h001F) begin errs++; $display("FAIL shadow_cur: got %h want 001f", cap0[15:0]); end
    vecs++; if (cap0[31:16] !== 16'h00FF) begin errs++; $display("FAIL shadow_next: got %h want 00ff", cap0[31:16]); end
    vecs++; if (cap0[47:32] !== 16'h0003) begin errs++; $display("FAIL shadow_bnd: got %h want 0003", cap0[47:32]); end
  endtask

  task automatic test_bad_ch();
    sync_pulse();
    wr(3, 9);
    sync_pulse();
    capture(32);
    vecs++; if (cap0[31:0] !== 32'h0003_0003) begin errs++; $display("FAIL badch_ch0: got %h want 00030003", cap0[31:0]); end
    vecs++; if (cap1[31:0] !== 32'h0000_0000) begin errs++; $display("FAIL badch_ch1: got %h want 00000000", cap1[31:0]); end
    vecs++; if (cap2[31:0] !== 32'hFFFF_FFFF) begin errs++; $display("FAIL badch_ch2: got %h want ffffffff", cap2[31:0]); end
  endtask

  task automatic test_center();
    sync_pulse();
    mode = 1'b1;
    wr(0, 4);
    sync_pulse();
    cap0 = '0; cap1 = '0; cap2 = '0; cap_pp = '0;
    for (int j = 0; j < 47; j++) begin
      sample(j);
      if (j == 10) mode = 1'b0;
      if (j < 46) tick();
    end
    vecs++; if (cap0[46:0] !== 47'h4003_F800_000F) begin errs++; $display("FAIL center_ch0: got %h want 4003f800000f", cap0[46:0]); end
    vecs++; if (cap_pp[46:0] !== 47'h4000_4000_0001) begin errs++; $display("FAIL center_pulse: got %h want 400040000001", cap_pp[46:0]); end
    vecs++; if (cap2[46:0] !== 47'h7FFF_FFFF_FFFF) begin errs++; $display("FAIL center_ch2: got %h want 7fffffffffff", cap2[46:0]); end
    vecs++; if (cap1[46:0] !== 47'h0) begin errs++; $display("FAIL center_ch1: got %h want 0", cap1[46:0]); end
  endtask

  task automatic test_disable();
    logic [28:0] exp0;
    exp0 = 29'h103F_F07F;
`ifdef PWM_POLARITY_EN
    pol  = 3'b001;
    exp0 = exp0 ^ 29'h1FFF_FFFF;
`endif
    sync_pulse();
    wr(0, 10);
    sync_pulse();
    cap0 = '0; cap1 = '0; cap2 = '0; cap_pp = '0;
    for (int j = 0; j < 29; j++) begin
      sample(j);
      if (j == 6)  en = 1'b0;
      if (j == 11) en = 1'b1;
      if (j < 28) tick();
    end
    vecs++; if (cap0[28:0] !== exp0) begin errs++; $display("FAIL dis_ch0: got %h want %h", cap0[28:0], exp0); end
    vecs++; if (cap_pp[28:0] !== 29'h1000_1001) begin errs++; $display("FAIL dis_pulse: got %h want 10001001", cap_pp[28:0]); end
    vecs++; if (cap2[28:0] !== 29'h1FFF_F07F) begin errs++; $display("FAIL dis_ch2: got %h want 1ffff07f", cap2[28:0]); end
`ifdef PWM_POLARITY_EN
    pol = 3'b000;
    repeat (2) tick();
`endif
  endtask

  task automatic test_reset_mid();
    sync_pulse();
    rst_n = 1'b0;
    #1;
    vecs++; if (pwm !== 3'b000) begin errs++; $display("FAIL midrst_pwm: got %b want 000", pwm); end
    vecs++; if (period_pulse !== 1'b0) begin errs++; $display("FAIL midrst_pulse: got %b want 0", period_pulse); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    vecs++; if (period_pulse !== 1'b1) begin errs++; $display("FAIL midrst_restart: got %b want 1", period_pulse); end
    capture(16);
    vecs++; if ((cap0[15:0] | cap1[15:0] | cap2[15:0]) !== 16'h0) begin
      errs++; $display("FAIL midrst_shadow_lost: got %h want 0000", cap0[15:0] | cap1[15:0] | cap2[15:0]);
    end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_shadow();
    test_bad_ch();
    test_center();
    test_disable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1);
  end
endmodule
